// File: rtl/serial_number_sender.sv
// Parallel-to-serial word source: emits a W-bit word MSB-first with running
// divisible-by-3 / divisible-by-5 flags for the prefix sent so far.
module serial_number_sender #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         new_bit,
    output logic         bit_valid,
    output logic         last,
    output logic         div_by_3,
    output logic         div_by_5
);

    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t         state, state_d;
    logic [W-1:0]   sr, sr_d;
    logic [CW-1:0]  cnt, cnt_d;
    logic           nb_d;
    logic [1:0]     r3, r3_d;
    logic [2:0]     r5, r5_d;
    logic           accept;
    logic           b;

    // (2*r + b) mod 3 by table lookup
    function automatic logic [1:0] next_r3(input logic [1:0] r, input logic bin);
        case ({r, bin})
            3'b000:  return 2'd0;
            3'b001:  return 2'd1;
            3'b010:  return 2'd2;
            3'b011:  return 2'd0;
            3'b100:  return 2'd1;
            3'b101:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    // (2*r + b) mod 5 by table lookup
    function automatic logic [2:0] next_r5(input logic [2:0] r, input logic bin);
        case ({r, bin})
            4'b0000: return 3'd0;
            4'b0001: return 3'd1;
            4'b0010: return 3'd2;
            4'b0011: return 3'd3;
            4'b0100: return 3'd4;
            4'b0101: return 3'd0;
            4'b0110: return 3'd1;
            4'b0111: return 3'd2;
            4'b1000: return 3'd3;
            4'b1001: return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    assign bit_valid = (state == SHIFT);
    assign last      = bit_valid && (cnt == '0);
    assign in_ready  = (state == IDLE) || last;
    assign div_by_3  = bit_valid && (r3 == 2'd0);
    assign div_by_5  = bit_valid && (r5 == 3'd0);
    assign accept    = in_valid && in_ready;
    assign b         = sr[W-1];

    // Next-state and datapath: a new word may load on the last bit with no bubble
    always_comb begin
        state_d = state;
        sr_d    = sr;
        cnt_d   = cnt;
        nb_d    = new_bit;
        r3_d    = r3;
        r5_d    = r5;
        if (accept) begin
            state_d = SHIFT;
            sr_d    = in_data << 1;
            nb_d    = in_data[W-1];
            cnt_d   = CW'(W - 1);
            r3_d    = {1'b0, in_data[W-1]};
            r5_d    = {2'b00, in_data[W-1]};
        end else if (state == SHIFT) begin
            if (cnt != '0) begin
                nb_d  = b;
                sr_d  = sr << 1;
                cnt_d = cnt - CW'(1);
                r3_d  = next_r3(r3, b);
                r5_d  = next_r5(r5, b);
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sr      <= '0;
            cnt     <= '0;
            new_bit <= 1'b0;
            r3      <= 2'd0;
            r5      <= 3'd0;
        end else begin
            state   <= state_d;
            sr      <= sr_d;
            cnt     <= cnt_d;
            new_bit <= nb_d;
            r3      <= r3_d;
            r5      <= r5_d;
        end
    end

endmodule

// File: tb/tb_serial_number_sender.sv
// Self-checking bench for serial_number_sender: directed word table, multi-cycle
// corner sequences and random words against a prefix-arithmetic model.
module tb_serial_number_sender;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready, new_bit, bit_valid, last, div_by_3, div_by_5;

    serial_number_sender #(.W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .new_bit  (new_bit),
        .bit_valid(bit_valid),
        .last     (last),
        .div_by_3 (div_by_3),
        .div_by_5 (div_by_5)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: word captured on accept, prefix value kept as an integer
    logic [W-1:0] m_word = '0;
    int           m_idx = 0;
    int           m_prefix = 0;
    bit           m_active = 1'b0;
    bit           m_acc = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0;
            m_idx    = 0;
            m_prefix = 0;
            m_acc    = 1'b0;
        end else begin
            m_acc = 1'b0;
            if (in_valid && (!m_active || m_idx == 0)) begin
                m_word   = in_data;
                m_idx    = W - 1;
                m_active = 1'b1;
                m_prefix = int'(in_data[W-1]);
                m_acc    = 1'b1;
            end else if (m_active) begin
                if (m_idx == 0) begin
                    m_active = 1'b0;
                end else begin
                    m_idx--;
                    m_prefix = m_prefix * 2 + int'(m_word[m_idx]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("bit_valid", bit_valid, m_active);
            check("in_ready", in_ready, !m_active || m_idx == 0);
            check("last", last, m_active && m_idx == 0);
            check("div_by_3", div_by_3, m_active && (m_prefix % 3 == 0));
            check("div_by_5", div_by_5, m_active && (m_prefix % 5 == 0));
            if (m_active)
                check("new_bit", new_bit, m_word[m_idx]);
        end
    end

    task automatic run_word(input logic [W-1:0] w, output logic d3, output logic d5);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = w;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (W - 1) @(negedge clk);
        check("tbl_last", last, 1'b1);
        d3 = div_by_3;
        d5 = div_by_5;
        @(negedge clk);
        check("tbl_valid_drop", bit_valid, 1'b0);
    endtask

    typedef struct {
        logic [W-1:0] word;
        logic         d3;
        logic         d5;
    } vec_t;

    vec_t         vecs[8];
    logic         got3, got5;
    logic [W-1:0] got;
    int           run, n, gap;

    initial begin
        vecs[0] = '{16'h0006, 1'b1, 1'b0};
        vecs[1] = '{16'hFFFF, 1'b1, 1'b1};
        vecs[2] = '{16'h0007, 1'b0, 1'b0};
        vecs[3] = '{16'h000F, 1'b1, 1'b1};
        vecs[4] = '{16'h0001, 1'b0, 1'b0};
        vecs[5] = '{16'h000A, 1'b0, 1'b1};
        vecs[6] = '{16'h0000, 1'b1, 1'b1};
        vecs[7] = '{16'h8000, 1'b0, 1'b0};

        repeat (2) @(negedge clk);
        check("rst_bit_valid", bit_valid, 1'b0);
        check("rst_last", last, 1'b0);
        check("rst_div3", div_by_3, 1'b0);
        check("rst_div5", div_by_5, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        foreach (vecs[i]) begin
            run_word(vecs[i].word, got3, got5);
            check($sformatf("tbl_d3_%0h", vecs[i].word), got3, vecs[i].d3);
            check($sformatf("tbl_d5_%0h", vecs[i].word), got5, vecs[i].d5);
        end

        // Back-to-back: second word accepted on the first word's last bit
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'h000F;
        run = 0;
        for (int c = 0; c < 34; c++) begin
            @(negedge clk);
            check($sformatf("b2b_ready_%0d", c), in_ready, (c == 15) || (c == 31) || (c >= 32));
            if (bit_valid && run == c) run++;
            if (c == 30) begin
                check("b2b_w2_d3_prefix0", div_by_3, 1'b1);
                check("b2b_w2_d5_prefix0", div_by_5, 1'b1);
            end
            if (c == 31) begin
                check("b2b_w2_d3_final", div_by_3, 1'b0);
                check("b2b_w2_d5_final", div_by_5, 1'b0);
            end
            if (c == 15) in_data = 16'h0001;
            if (c == 16) in_valid = 1'b0;
        end
        check_int("b2b_valid_run", run, 32);

        // Stall: valid held with changing data while not ready
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'h1234;
        got = '0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            got = {got[W-2:0], new_bit};
            if (c < 15) in_data = W'($urandom);
            else        in_valid = 1'b0;
        end
        check_int("stall_word", int'(got), 32'h1234);
        @(negedge clk);
        check("stall_valid_drop", bit_valid, 1'b0);

        // Asynchronous reset in the middle of a word
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'hABCD;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_bit_valid", bit_valid, 1'b0);
        check("arst_last", last, 1'b0);
        check("arst_div3", div_by_3, 1'b0);
        check("arst_div5", div_by_5, 1'b0);
        check("arst_in_ready", in_ready, 1'b1);
        check("arst_new_bit", new_bit, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("arst_no_stale", bit_valid, 1'b0);
        end

        // Random words with random gaps
        for (int i = 0; i < 1000; i++) begin
            gap = int'($urandom_range(0, 2));
            if (gap > 0) begin
                in_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = W'($urandom);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!m_acc && n < 40);
            check("rand_accept", m_acc, 1'b1);
        end
        in_valid = 1'b0;
        repeat (W + 2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_number_sender.md
# serial_number_sender

Parallel-to-serial source for the serial divisibility checkers. It accepts a W-bit word over a valid/ready handshake and emits it MSB-first, one bit per clock, on `new_bit`. Alongside each bit it computes reference `div_by_3`/`div_by_5` flags for the prefix sent so far. It sits upstream of `serial_divisibility_by_3_using_fsm`/`..._by_5_...`, either as their stimulus generator or as a self-checking source in integration.

## Interface
- `W`, default 16: word width; legal range W >= 1.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream word available.
- `in_ready`  out  1  block can accept a word this cycle.
- `in_data`  in  W  word to serialize; sampled on accept.
- `new_bit`  out  1  current serial bit, MSB first.
- `bit_valid`  out  1  `new_bit` is meaningful this cycle.
- `last`  out  1  current bit is the LSB of the word.
- `div_by_3`  out  1  prefix including current bit is ≡ 0 mod 3; gated by `bit_valid`.
- `div_by_5`  out  1  prefix including current bit is ≡ 0 mod 5; gated by `bit_valid`.

## Operation
- FSM states: IDLE, SHIFT.
- Accept: `in_valid && in_ready` at a rising edge.
- `in_ready` is combinational: 1 in IDLE, or in SHIFT when `last` = 1. It is 0 in SHIFT otherwise.
- On accept, all of the following are registered together:
  - shift register <= `in_data << 1`;
  - `new_bit` <= `in_data[W-1]`;
  - bit counter <= W-1;
  - r3 <= `in_data[W-1]`, r5 <= `in_data[W-1]` (residues restart for every word);
  - state <= SHIFT.
- Each SHIFT cycle with counter != 0:
  - `new_bit` <= shift register MSB, then the shift register shifts left;
  - counter decrements;
  - r3 <= (2·r3 + b) mod 3 and r5 <= (2·r5 + b) mod 5, where b is the incoming bit.
- Residue widths: r3 is 2 bits, r5 is 3 bits. Only the values 0..2 and 0..4 are ever reachable. Updates use a lookup or compare-subtract, not a divider.
- Last bit (counter == 0, SHIFT):
  - With an accept: behave exactly as the accept step above. The next word's MSB follows with no bubble.
  - Without an accept: state <= IDLE and `bit_valid` <= 0.
- Derived outputs:
  - `bit_valid` = (state == SHIFT).
  - `last` = `bit_valid` && counter == 0.
  - `div_by_3` = `bit_valid` && r3 == 0.
  - `div_by_5` = `bit_valid` && r5 == 0.
- `in_valid` while `in_ready` = 0 is ignored; the upstream must hold the word. `in_data` changes while not ready are ignored.
- W = 1: each word is a single cycle with `last` = 1 on its only bit.

## Timing
- Reset (`rst_n` low, asynchronous): state IDLE, counter 0, r3/r5 0, `new_bit` 0. Outputs become `bit_valid` 0, `last` 0, `div_by_3` 0, `div_by_5` 0, `in_ready` 1.
- Reset mid-word aborts the word immediately; no partial bits are emitted after reset is released.
- No accept is possible while `rst_n` = 0.
- Latency: accept at edge k puts the MSB on `new_bit` from edge k through edge k+1. The LSB is presented W-1 cycles later with `last` = 1.
- `bit_valid` is high for exactly W consecutive cycles per word.
- Back-to-back words produce an unbroken `bit_valid` run of N·W cycles.
- The flags are valid in the same cycle as their bit, so they match what a downstream FSM reports one edge after sampling that bit.

## Test plan
- **Reset values:** assert `rst_n` low mid-word, asynchronously between edges → all outputs 0 and `in_ready` 1 immediately. After release, no stale bits appear.
- **Single word 16'h0006:** 13 bits of 0 with div3 = 1, div5 = 1; then bit 1 (div3 0, div5 0); bit 1 (prefix 3: div3 1, div5 0); bit 0 (prefix 6: div3 1, div5 0, `last` 1). `bit_valid` falls the next cycle.
- **Word 16'hFFFF (65535):** final bit gives div3 = 1 and div5 = 1. Word 16'h0007 gives final div3 = 0 and div5 = 0.
- **Back-to-back 16'h000F then 16'h0001:** `in_ready` is high only on the `last` cycle, and the second accept happens there. 32 contiguous `bit_valid` cycles. Residues restart, so the second word shows div3/div5 = 1 for its first 15 bits and 0 on its final bit.
- **Stall:** `in_valid` held high mid-word with changing `in_data` → those words are not accepted, and the current word is emitted unchanged.
- **Random:** 1000 random words with random `in_valid` gaps, checked against a bench model (prefix % 3, % 5). Also chain the block into the existing divisibility FSMs and require their outputs to match this block's flags, delayed by one cycle.
